// File: rtl/cylon_gen_if.sv
// cylon_gen_if: control and LED output bundle for cylon_gen.
//   enable  run/freeze control (master -> slave)
//   rate    prescaler increment minus one (master -> slave)
//   mode    pattern select, 0..3 (master -> slave)
//   q       registered LED pattern, bit 0 = first LED (slave -> master)
//   step    one-clock pulse on each pattern advance (slave -> master)
interface cylon_gen_if #(
  parameter int WIDTH  = 12,
  parameter int MXRATE = 2
);
  logic              enable;
  logic [MXRATE-1:0] rate;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  q;
  logic              step;

  modport master (output enable, rate, mode, input  q, step);
  modport slave  (input  enable, rate, mode, output q, step);
endinterface

// File: rtl/cylon_gen.sv
// cylon_gen: front-panel LED sequence generator.
// Drives WIDTH LEDs with one of four run-time patterns, stepped at a rate set
// by a carry-out prescaler: single-eye bounce, mirrored two-eye bounce,
// walking wrap and all-LED blink.
// Ports:
//   clock  fabric clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    cylon_gen_if slave: enable, rate, mode in; q, step out
module cylon_gen #(
  parameter int WIDTH  = 12,
  parameter int MXPRE  = 21,
  parameter int MXRATE = 2
) (
  input  logic        clock,
  input  logic        reset,
  cylon_gen_if.slave  bus
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] LIM_FULL = PW'(WIDTH - 1);
  localparam logic [PW-1:0] LIM_HALF = PW'((WIDTH + 1) / 2 - 1);

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_MIRROR = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [MXPRE-1:0] presc;
  logic [MXPRE:0]   presc_sum;
  logic             tick;
  logic             mode_chg;
  mode_e            mode_in;
  mode_e            mode_r;
  dir_e             dir;
  logic             phase;
  logic [PW-1:0]    pos;
  logic [PW-1:0]    lim;
  logic             tick_pend;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] q_r;
  logic             step_r;

  assign mode_in = mode_e'(bus.mode);
  assign mode_chg = (mode_in != mode_r);

  // The step rate comes from the carry out of the accumulator rather than an
  // equality compare, so any increment (including non powers of two) ticks.
  assign presc_sum = {1'b0, presc} + (MXPRE+1)'(bus.rate) + (MXPRE+1)'(1);
  assign tick = bus.enable & presc_sum[MXPRE];

  // Bounce turning point: half-width in mirrored mode since the two eyes meet
  // in the middle, full width otherwise.
  assign lim = (mode_r == MODE_MIRROR) ? LIM_HALF : LIM_FULL;

  always_comb begin
    pattern = '0;
    unique case (mode_r)
      MODE_BLINK: pattern = phase ? '1 : '0;
      MODE_MIRROR: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if ((PW'(i) == pos) || (PW'(WIDTH - 1 - i) == pos))
            pattern[i] = 1'b1;
        end
      end
      default: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (PW'(i) == pos)
            pattern[i] = 1'b1;
        end
      end
    endcase
  end

  // State moves on a tick; q follows one clock later from the settled state,
  // so step is the tick delayed by one clock to line up with the q change.
  // A mode change restarts the sequence and swallows any coincident tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc     <= '0;
      pos       <= '0;
      dir       <= DIR_UP;
      phase     <= 1'b0;
      mode_r    <= mode_in;
      tick_pend <= 1'b0;
      q_r       <= '0;
      step_r    <= 1'b0;
    end else begin
      mode_r    <= mode_in;
      q_r       <= pattern;
      step_r    <= tick_pend;
      tick_pend <= tick & ~mode_chg;

      if (bus.enable)
        presc <= presc_sum[MXPRE-1:0];

      if (mode_chg) begin
        pos   <= '0;
        dir   <= DIR_UP;
        phase <= 1'b0;
      end else if (tick) begin
        unique case (mode_r)
          MODE_SINGLE, MODE_MIRROR: begin
            // A zero limit (two LEDs, mirrored) keeps both eyes parked.
            if (dir == DIR_UP) begin
              if (pos >= lim) begin
                dir <= DIR_DOWN;
                pos <= (lim == '0) ? '0 : lim - PW'(1);
              end else begin
                pos <= pos + PW'(1);
              end
            end else begin
              if (pos == '0) begin
                dir <= DIR_UP;
                pos <= (lim == '0) ? '0 : PW'(1);
              end else begin
                pos <= pos - PW'(1);
              end
            end
          end
          MODE_WALK: begin
            dir <= DIR_UP;
            pos <= (pos >= LIM_FULL) ? '0 : pos + PW'(1);
          end
          MODE_BLINK: begin
            phase <= ~phase;
          end
        endcase
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.step = step_r;

endmodule

// File: tb/tb_cylon_gen.sv
module tb_cylon_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cylon_gen_if #(.WIDTH(8), .MXRATE(2)) bus ();
  cylon_gen_if #(.WIDTH(7), .MXRATE(2)) bus7 ();

  assign bus7.enable = bus.enable;
  assign bus7.rate   = bus.rate;
  assign bus7.mode   = bus.mode;

  cylon_gen #(.WIDTH(8), .MXPRE(3), .MXRATE(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  cylon_gen #(.WIDTH(7), .MXPRE(3), .MXRATE(2)) dut7 (
    .clock (clock),
    .reset (reset),
    .bus   (bus7.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [$];
  logic [6:0] exp_q7 [$];

  logic [7:0] seq_single [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] seq_mirror [6]  = '{8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h81};
  logic [6:0] seq_mirror7 [6] = '{7'h22, 7'h14, 7'h08, 7'h14, 7'h22, 7'h41};
  logic [7:0] seq_walk [8]    = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] seq_blink [4]   = '{8'hFF, 8'h00, 8'hFF, 8'h00};

  // Waits (bounded) for the next step pulse; cyc counts negedges waited.
  task automatic wait_step(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 64) begin
      @(negedge clock);
      cyc++;
      got = bus.step;
    end
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [1:0] r);
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.mode = m;
    bus.rate = r;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    int cyc;
    bit got;
    bus.mode = 2'd0; bus.rate = 2'd0; bus.enable = 1'b1; reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", bus.q); end
    checks++;
    if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", bus.step); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.q !== 8'h01) begin errors++; $display("FAIL first_q: got %h expected 01", bus.q); end
    wait_step(cyc, got);
    checks++;
    if (!got || cyc != 8) begin errors++; $display("FAIL first_tick: got=%0d cyc=%0d expected cyc 8", got, cyc); end
    checks++;
    if (bus.q !== 8'h02) begin errors++; $display("FAIL first_step_q: got %h expected 02", bus.q); end
  endtask

  task automatic test_single();
    int cyc;
    bit got;
    logic [7:0] e;
    do_reset(2'd0, 2'd0);
    foreach (seq_single[i]) exp_q.push_back(seq_single[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || cyc != 8) begin errors++; $display("FAIL single_interval: got=%0d cyc=%0d expected 8", got, cyc); end
      checks++;
      if (bus.q !== e) begin errors++; $display("FAIL single_q: got %h expected %h", bus.q, e); end
    end
  endtask

  task automatic test_rate();
    int cyc;
    bit got;
    logic [7:0] e;
    do_reset(2'd0, 2'd3);
    foreach (seq_single[i]) exp_q.push_back(seq_single[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || cyc != 2) begin errors++; $display("FAIL rate3_interval: got=%0d cyc=%0d expected 2", got, cyc); end
      checks++;
      if (bus.q !== e) begin errors++; $display("FAIL rate3_q: got %h expected %h", bus.q, e); end
    end
    // Change rate on the fly; first interval spans the old and new increment.
    bus.rate = 2'd1;
    foreach (seq_single[i]) exp_q.push_back(seq_single[i]);
    for (int n = 0; n < 14; n++) begin
      e = exp_q.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || cyc != ((n == 0) ? 3 : 4)) begin
        errors++; $display("FAIL rate1_interval: got=%0d cyc=%0d expected %0d", got, cyc, (n == 0) ? 3 : 4);
      end
      checks++;
      if (bus.q !== e) begin errors++; $display("FAIL rate1_q: got %h expected %h", bus.q, e); end
    end
  endtask

  task automatic test_mirror();
    int cyc;
    bit got;
    logic [7:0] e;
    logic [6:0] e7;
    do_reset(2'd1, 2'd0);
    checks++;
    if (bus.q !== 8'h81) begin errors++; $display("FAIL mirror_first: got %h expected 81", bus.q); end
    checks++;
    if (bus7.q !== 7'h41) begin errors++; $display("FAIL mirror7_first: got %h expected 41", bus7.q); end
    foreach (seq_mirror[i]) begin
      exp_q.push_back(seq_mirror[i]);
      exp_q7.push_back(seq_mirror7[i]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e7 = exp_q7.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || cyc != 8) begin errors++; $display("FAIL mirror_interval: got=%0d cyc=%0d expected 8", got, cyc); end
      checks++;
      if (bus.q !== e) begin errors++; $display("FAIL mirror_q: got %h expected %h", bus.q, e); end
      checks++;
      if (bus7.step !== 1'b1 || bus7.q !== e7) begin
        errors++; $display("FAIL mirror7_q: got %h step %b expected %h step 1", bus7.q, bus7.step, e7);
      end
    end
  endtask

  task automatic test_walk_blink();
    int cyc;
    bit got;
    bit bad;
    logic [7:0] e;
    do_reset(2'd2, 2'd0);
    checks++;
    if (bus.q !== 8'h01) begin errors++; $display("FAIL walk_first: got %h expected 01", bus.q); end
    foreach (seq_walk[i]) exp_q.push_back(seq_walk[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || bus.q !== e) begin errors++; $display("FAIL walk_q: got %h step %0d expected %h", bus.q, got, e); end
    end
    bus.mode = 2'd3;
    bad = 1'b0;
    @(negedge clock);
    if (bus.step !== 1'b0) bad = 1'b1;
    @(negedge clock);
    if (bus.step !== 1'b0) bad = 1'b1;
    checks++;
    if (bad || bus.q !== 8'h00) begin errors++; $display("FAIL blink_restart: got %h extra_step %0d expected 00", bus.q, bad); end
    foreach (seq_blink[i]) exp_q.push_back(seq_blink[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || bus.q !== e) begin errors++; $display("FAIL blink_q: got %h step %0d expected %h", bus.q, got, e); end
    end
  endtask

  task automatic test_mode_change();
    int cyc;
    bit got;
    bit bad;
    logic [7:0] e;
    do_reset(2'd0, 2'd0);
    for (int i = 0; i < 5; i++) exp_q.push_back(seq_single[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || bus.q !== e) begin errors++; $display("FAIL mc_pre_q: got %h step %0d expected %h", bus.q, got, e); end
    end
    // q=20: switch 0->2 mid-interval.
    bus.mode = 2'd2;
    bad = 1'b0;
    @(negedge clock);
    if (bus.step !== 1'b0) bad = 1'b1;
    @(negedge clock);
    if (bus.step !== 1'b0) bad = 1'b1;
    checks++;
    if (bad || bus.q !== 8'h01) begin errors++; $display("FAIL mc_0to2: got %h extra_step %0d expected 01", bus.q, bad); end
    wait_step(cyc, got);
    checks++;
    if (!got || cyc != 6 || bus.q !== 8'h02) begin
      errors++; $display("FAIL mc_walk_step: got %h cyc %0d expected 02 cyc 6", bus.q, cyc);
    end
    // Next tick edge is 7 clocks after this step's edge; switch right before it.
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.step !== 1'b0) bad = 1'b1;
    end
    bus.mode = 2'd1;
    @(negedge clock);
    if (bus.step !== 1'b0) bad = 1'b1;
    @(negedge clock);
    if (bus.step !== 1'b0) bad = 1'b1;
    checks++;
    if (bad || bus.q !== 8'h81) begin errors++; $display("FAIL mc_2to1_tick: got %h extra_step %0d expected 81", bus.q, bad); end
    wait_step(cyc, got);
    checks++;
    if (!got || cyc != 8 || bus.q !== 8'h42) begin
      errors++; $display("FAIL mc_after_restart: got %h cyc %0d expected 42 cyc 8", bus.q, cyc);
    end
  endtask

  task automatic test_freeze_reset();
    int cyc;
    bit got;
    bit bad;
    logic [7:0] e;
    do_reset(2'd0, 2'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(seq_single[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || bus.q !== e) begin errors++; $display("FAIL frz_pre_q: got %h step %0d expected %h", bus.q, got, e); end
    end
    repeat (3) @(negedge clock);
    bus.enable = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.q !== 8'h08 || bus.step !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL freeze_hold: got %h step %b expected 08 step 0", bus.q, bus.step); end
    bus.enable = 1'b1;
    wait_step(cyc, got);
    checks++;
    if (!got || cyc != 5 || bus.q !== 8'h10) begin
      errors++; $display("FAIL freeze_resume: got %h cyc %0d expected 10 cyc 5", bus.q, cyc);
    end
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_step(cyc, got);
      checks++;
      if (!got || bus.q !== e) begin errors++; $display("FAIL frz_post_q: got %h step %0d expected %h", bus.q, got, e); end
    end
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.q !== 8'h00 || bus.step !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL midsweep_reset: got %h step %b expected 00 step 0", bus.q, bus.step); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.q !== 8'h01) begin errors++; $display("FAIL post_reset_q: got %h expected 01", bus.q); end
    wait_step(cyc, got);
    checks++;
    if (!got || cyc != 8 || bus.q !== 8'h02) begin
      errors++; $display("FAIL post_reset_step: got %h cyc %0d expected 02 cyc 8", bus.q, cyc);
    end
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.rate = 2'd0;
    bus.mode = 2'd0;
    test_reset();
    test_single();
    test_rate();
    test_mirror();
    test_walk_blink();
    test_mode_change();
    test_freeze_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
